// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared types for the ALU arbiter and its ALU core
package ula_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } arb_state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational AND/OR/ADD/SUB with carry/borrow flag
module alu_core
    import ula_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_op_t      op,
    output logic [W-1:0] result,
    output logic         flag
);

    logic [W:0] sum;
    logic [W:0] diff;

    // The extra top bit of the widened difference is the unsigned borrow.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        flag   = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                result = sum[W-1:0];
                flag   = sum[W];
            end
            OP_SUB: begin
                result = diff[W-1:0];
                flag   = diff[W];
            end
            default: begin
                result = '0;
                flag   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - round-robin sharing of one ALU among N_REQ requesters
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = DEFAULT_W,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    input  logic [N_REQ*2-1:0]   req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_result,
    output logic                 rsp_flag,
    output logic                 busy
);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    alu_op_t        op_q, op_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_result_q, rsp_result_d;
    logic           rsp_flag_q, rsp_flag_d;

    logic [W-1:0]   alu_result;
    logic           alu_flag;
    logic [IDW:0]   pick;
    logic           win_found;
    logic [IDW-1:0] win_id;

    // Returns {found, index} of the first valid requester at or after ptr.
    function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] valid,
                                             input logic [IDW-1:0]   ptr);
        logic           found;
        logic [IDW-1:0] idx;
        int             j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!found && valid[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
        return {found, idx};
    endfunction

    assign pick      = rr_pick(req_valid, rr_ptr_q);
    assign win_found = pick[IDW];
    assign win_id    = pick[IDW-1:0];

    alu_core #(.W(W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .flag   (alu_flag)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flag_d   = rsp_flag_q;
        req_ready    = '0;
        case (state_q)
            S_IDLE: begin
                // Gated by rst_n so the grant strobe also drops during reset.
                if (win_found && rst_n) begin
                    req_ready[win_id] = 1'b1;
                    a_d      = req_a[int'(win_id)*W +: W];
                    b_d      = req_b[int'(win_id)*W +: W];
                    op_d     = alu_op_t'(req_op[int'(win_id)*2 +: 2]);
                    id_d     = win_id;
                    rr_ptr_d = IDW'((int'(win_id) + 1) % N_REQ);
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_result_d = alu_result;
                rsp_flag_d   = alu_flag;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_AND;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flag_q   <= rsp_flag_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flag   = rsp_flag_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ula_arbiter.sv
// tb/tb_ula_arbiter.sv - scoreboard bench for ula_arbiter
module tb_ula_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*2-1:0] req_op;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_flag;
    logic           busy;

    always #5 clk = ~clk;

    ula_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flag   (rsp_flag),
        .busy       (busy)
    );

    typedef struct {
        int id;
        int result;
        int flag;
    } exp_t;

    exp_t   sb[$];
    int     n_chk = 0;
    int     n_pass = 0;
    int     cyc = 0;
    int     model_rr = 0;
    bit     outstanding = 0;
    int     grant_cyc = 0;
    bit     seen_rsp = 0;
    bit     prev_stall = 0;
    int     prev_pack = 0;
    logic [N-1:0] last_ready = '0;

    bit     pend [N];
    int     pa [N];
    int     pb [N];
    int     po [N];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic exp_t model_op(input int id, input int a, input int b, input int op);
        exp_t e;
        e.id = id;
        e.flag = 0;
        case (op)
            0: e.result = a & b;
            1: e.result = a | b;
            2: begin e.result = (a + b) % 256; e.flag = (a + b > 255) ? 1 : 0; end
            default: begin e.result = (a - b + 256) % 256; e.flag = (a < b) ? 1 : 0; end
        endcase
        return e;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*W +: W]    = W'(pa[i]);
            req_b[i*W +: W]    = W'(pb[i]);
            req_op[i*2 +: 2]   = 2'(po[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (last_ready[i]) pend[i] = 0;
        drive();
    endtask

    task automatic set_req(input int i, input int a, input int b, input int op);
        pend[i] = 1; pa[i] = a; pb[i] = b; po[i] = op;
        drive();
    endtask

    task automatic issue(input int i, input int a, input int b, input int op);
        int k;
        set_req(i, a, b, op);
        k = 0;
        while (pend[i] && k < 30) begin step(); k++; end
        if (pend[i]) chk("accept_timeout", 0, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 0);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_id"}, int'(rsp_id), 0);
        chk({tag, "_rsp_result"}, int'(rsp_result), 0);
        chk({tag, "_rsp_flag"}, int'(rsp_flag), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Monitor: predicts grants from the bench's own request vector and checks responses.
    always @(negedge clk) begin
        int   w;
        int   expv;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            last_ready = '0;
            prev_stall = 0;
        end else begin
            chk("onehot", int'($countones(req_ready) <= 1), 1);
            chk("busy", int'(busy), int'(outstanding));
            if (!outstanding) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req_valid[(model_rr + k) % N]) w = (model_rr + k) % N;
                expv = (w >= 0) ? (1 << w) : 0;
                chk("grant", int'(req_ready), expv);
                if (w >= 0) begin
                    sb.push_back(model_op(w, pa[w], pb[w], po[w]));
                    model_rr = (w + 1) % N;
                    outstanding = 1;
                    grant_cyc = cyc;
                    seen_rsp = 0;
                end
            end else begin
                chk("no_grant_busy", int'(req_ready), 0);
            end
            if (prev_stall)
                chk("stall_hold", int'({rsp_valid, rsp_id, rsp_result, rsp_flag}), prev_pack);
            if (rsp_valid && outstanding && !seen_rsp) begin
                chk("latency", cyc - grant_cyc, 2);
                seen_rsp = 1;
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", int'(rsp_id), e.id);
                    chk("rsp_result", int'(rsp_result), e.result);
                    chk("rsp_flag", int'(rsp_flag), e.flag);
                end
                outstanding = 0;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_pack  = int'({rsp_valid, rsp_id, rsp_result, rsp_flag});
            last_ready = req_ready;
        end
    end

    initial begin
        int k;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin pend[i] = 0; pa[i] = 0; pb[i] = 0; po[i] = 0; end
        pend[2] = 1; pa[2] = 7; pb[2] = 9; po[2] = 2;
        drive();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        k = 0;
        while (pend[2] && k < 10) begin step(); k++; end

        issue(0, 200, 100, 2);
        issue(2, 5, 10, 3);
        issue(2, 10, 5, 3);
        issue(1, 'hF0, 'h3C, 0);
        issue(1, 'hF0, 'h3C, 1);

        for (int i = 0; i < N; i++) set_req(i, 16 * i + 1, i + 3, i);
        k = 0;
        while ((pend[0] || pend[1] || pend[2] || pend[3]) && k < 60) begin step(); k++; end
        chk("all_four_drained", int'(pend[0] || pend[1] || pend[2] || pend[3]), 0);

        rsp_ready = 1'b0;
        set_req(3, 99, 1, 3);
        set_req(1, 250, 10, 2);
        k = 0;
        while (pend[3] && pend[1] && k < 20) begin step(); k++; end
        repeat (7) step();
        rsp_ready = 1'b1;
        k = 0;
        while ((pend[3] || pend[1]) && k < 30) begin step(); k++; end

        for (int c = 0; c < 600; c++) begin
            step();
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    if ($urandom_range(0, 15) == 0) pend[i] = 0;
                end else if ($urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    pa[i] = $urandom_range(0, 255);
                    pb[i] = $urandom_range(0, 255);
                    po[i] = $urandom_range(0, 3);
                end
            end
            drive();
        end

        for (int i = 0; i < N; i++) pend[i] = 0;
        rsp_ready = 1'b1;
        drive();
        k = 0;
        while (outstanding && k < 20) begin step(); k++; end
        set_req(1, 3, 4, 2);
        k = 0;
        while (pend[1] && k < 20) begin step(); k++; end
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_exec_reset");
        sb.delete();
        model_rr = 0;
        outstanding = 0;
        repeat (2) step();
        set_req(3, 40, 2, 3);
        set_req(0, 1, 2, 2);
        rst_n = 1'b1;
        k = 0;
        while ((pend[0] || pend[3]) && k < 30) begin step(); k++; end

        k = 0;
        while ((outstanding || sb.size() != 0) && k < 50) begin step(); k++; end
        chk("drain", int'(outstanding) + sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
